// File: rtl/tpu_pkg.sv
// Shared TPU datapath types: the MMU result word and accumulator addressing.
package tpu_pkg;

    localparam int WORD_WIDTH             = 32;
    localparam int DEFAULT_ACC_ADDR_WIDTH = 8;

    typedef logic [WORD_WIDTH-1:0]             word_type;
    typedef logic [DEFAULT_ACC_ADDR_WIDTH-1:0] acc_addr_type;

endpackage

// File: rtl/systolic_delay_line.sv
// Enabled shift register of DEPTH stages with synchronous clear.
// DEPTH = 0 degenerates to a wire.
module systolic_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, enable};
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_p [DEPTH];

        // Shift one position per enabled cycle; clear every stage on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_p[i] <= '0;
                end
            end else if (enable) begin
                stage_p[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_p[i] <= stage_p[i-1];
                end
            end
        end

        assign q = stage_p[DEPTH-1];
    end

endmodule

// File: rtl/systolic_result_deskew_unit.sv
// Removes the column skew of MMU result rows: column j is delayed by
// (MATRIX_WIDTH-1-j) enabled cycles so a whole row lines up, and the row's
// accumulator address / accumulate flag ride alongside it.
module systolic_result_deskew_unit
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH   = 14,
    parameter int ACC_ADDR_WIDTH = DEFAULT_ACC_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          valid_in,
    input  logic [ACC_ADDR_WIDTH-1:0]     addr_in,
    input  logic                          accumulate_in,
    input  word_type [MATRIX_WIDTH-1:0]   data_in,
    output word_type [MATRIX_WIDTH-1:0]   data_out,
    output logic                          valid_out,
    output logic [ACC_ADDR_WIDTH-1:0]     addr_out,
    output logic                          accumulate_out,
    output logic                          busy
);

    localparam int SB_W  = ACC_ADDR_WIDTH + 2;
    localparam int CNT_W = $clog2(MATRIX_WIDTH + 2);

    // ---- stage p0: per-column deskew delay lines and sideband delay ----
    word_type [MATRIX_WIDTH-1:0] col_p0;
    logic [SB_W-1:0]             sb_in;
    logic [SB_W-1:0]             sb_p0;

    for (genvar j = 0; j < MATRIX_WIDTH; j++) begin : g_col
        systolic_delay_line #(
            .WIDTH (WORD_WIDTH),
            .DEPTH (MATRIX_WIDTH - 1 - j)
        ) u_col_delay (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .d      (data_in[j]),
            .q      (col_p0[j])
        );
    end

    assign sb_in = {valid_in, addr_in, accumulate_in};

    systolic_delay_line #(
        .WIDTH (SB_W),
        .DEPTH (MATRIX_WIDTH - 1)
    ) u_sideband_delay (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (sb_in),
        .q      (sb_p0)
    );

    // ---- stage p1: aligned output register ----
    word_type [MATRIX_WIDTH-1:0]  data_p1;
    logic                         vld_p1;
    logic [ACC_ADDR_WIDTH-1:0]    addr_p1;
    logic                         acc_p1;

    // Capture the aligned row and its sideband once every column has arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            acc_p1  <= 1'b0;
        end else if (enable) begin
            data_p1                   <= col_p0;
            {vld_p1, addr_p1, acc_p1} <= sb_p0;
        end
    end

    assign data_out       = data_p1;
    assign addr_out       = addr_p1;
    assign accumulate_out = acc_p1;
    // A frozen cycle must not report the row; it is reported once enable returns.
    assign valid_out      = vld_p1 & enable;

    logic             row_accepted;
    logic             row_emitted;
    logic [CNT_W-1:0] inflight_count;

    assign row_accepted = enable & valid_in;
    assign row_emitted  = enable & vld_p1;

    // Track rows accepted but not yet emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_count <= '0;
        end else begin
            case ({row_accepted, row_emitted})
                2'b10:   inflight_count <= inflight_count + CNT_W'(1);
                2'b01:   inflight_count <= inflight_count - CNT_W'(1);
                default: inflight_count <= inflight_count;
            endcase
        end
    end

    assign busy = (inflight_count != '0);

    // An emitted row must always have been counted in.
    always_ff @(posedge clk) begin
        if (!rst && row_emitted && !row_accepted) begin
            assert (inflight_count != '0);
        end
    end

endmodule

// File: tb/tb_systolic_result_deskew_unit.sv
// Directed bench for the result deskew unit (MATRIX_WIDTH = 4) plus a
// randomised scoreboard run on a MATRIX_WIDTH = 14 instance.
module tb_systolic_result_deskew_unit;
    import tpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic           en4, v4, c4;
    logic [7:0]     a4;
    word_type [3:0] din4, dout4;
    logic           vo4, co4, b4;
    logic [7:0]     ao4;

    logic            en14, v14, c14;
    logic [7:0]      a14;
    word_type [13:0] din14, dout14;
    logic            vo14, co14, b14;
    logic [7:0]      ao14;

    int compared   = 0;
    int mismatched = 0;

    systolic_result_deskew_unit #(.MATRIX_WIDTH(4), .ACC_ADDR_WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .valid_in(v4), .addr_in(a4),
        .accumulate_in(c4), .data_in(din4), .data_out(dout4), .valid_out(vo4),
        .addr_out(ao4), .accumulate_out(co4), .busy(b4)
    );

    systolic_result_deskew_unit #(.MATRIX_WIDTH(14), .ACC_ADDR_WIDTH(8)) dut14 (
        .clk(clk), .rst(rst), .enable(en14), .valid_in(v14), .addr_in(a14),
        .accumulate_in(c14), .data_in(din14), .data_out(dout14), .valid_out(vo14),
        .addr_out(ao14), .accumulate_out(co14), .busy(b14)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [127:0] row4(input int r);
        return {32'(100*r+3), 32'(100*r+2), 32'(100*r+1), 32'(100*r)};
    endfunction

    // scoreboard storage for the random run, indexed by enabled cycle mod 32
    logic     rv [32];
    logic [7:0] ra [32];
    logic     rc [32];
    word_type rw [32][14];

    initial begin
        int e;
        int seen;
        int ecount;
        int mcount;
        int oi;
        logic exp_v;
        word_type [13:0] exp_row;

        rst = 1'b1;
        en4 = 1'b1; v4 = 1'b0; c4 = 1'b0; a4 = '0; din4 = '0;
        en14 = 1'b1; v14 = 1'b0; c14 = 1'b0; a14 = '0; din14 = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        en14 = 1'b0;
        sample();
        check("rst_data", dout4, 128'h0);
        check("rst_valid", vo4, 1'b0);
        check("rst_addr", ao4, 8'h00);
        check("rst_acc", co4, 1'b0);
        check("rst_busy", b4, 1'b0);
        check("rst_busy14", b14, 1'b0);

        // Test 1: single row, enable high
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            v4 = (c == 0);
            a4 = (c == 0) ? 8'h12 : 8'h00;
            c4 = (c == 0);
            din4 = '0;
            if (c < 4) din4[c] = 32'(10 + c);
            sample();
            check("t1_valid", vo4, (c == 4));
            check("t1_busy", b4, (c >= 1 && c <= 4));
            if (c == 4) begin
                check("t1_data", dout4, {32'd13, 32'd12, 32'd11, 32'd10});
                check("t1_addr", ao4, 8'h12);
                check("t1_acc", co4, 1'b1);
            end
        end

        // Test 2: four back-to-back rows
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            v4 = (c < 4);
            a4 = 8'((c < 4) ? c : 0);
            c4 = 1'b0;
            for (int j = 0; j < 4; j++) begin
                din4[j] = (c - j >= 0 && c - j < 4) ? 32'(100*(c-j) + j) : 32'h0;
            end
            sample();
            check("t2_valid", vo4, (c >= 4 && c <= 7));
            if (c >= 4 && c <= 7) begin
                check("t2_data", dout4, row4(c - 4));
                check("t2_addr", ao4, 8'(c - 4));
                check("t2_acc", co4, 1'b0);
            end
            if (c == 8) check("t2_busy_idle", b4, 1'b0);
        end

        // Test 3: freeze on cycles 2 and 3
        e = 0;
        seen = 0;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            en4 = (c != 2 && c != 3);
            v4 = (c == 0);
            a4 = (c == 0) ? 8'h12 : 8'h00;
            c4 = (c == 0);
            din4 = '0;
            if (en4 && e < 4) din4[e] = 32'(10 + e);
            sample();
            check("t3_valid", vo4, (c == 6));
            check("t3_busy", b4, (c >= 1 && c <= 6));
            if (vo4 === 1'b1) seen++;
            if (c == 6) begin
                check("t3_data", dout4, {32'd13, 32'd12, 32'd11, 32'd10});
                check("t3_addr", ao4, 8'h12);
                check("t3_acc", co4, 1'b1);
            end
            if (en4) e++;
        end
        check("t3_row_count", 32'(seen), 32'd1);
        en4 = 1'b1;

        // Test 4: reset mid-flight
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            rst = (c == 2);
            v4 = (c < 2);
            a4 = (c == 0) ? 8'h01 : ((c == 1) ? 8'h02 : 8'h00);
            c4 = (c < 2);
            din4 = '0;
            if (c < 2) din4[0] = 32'(5 + c);
            if (c == 1) din4[1] = 32'd7;
            sample();
            if (c >= 3) begin
                check("t4_data", dout4, 128'h0);
                check("t4_valid", vo4, 1'b0);
                check("t4_addr", ao4, 8'h00);
                check("t4_acc", co4, 1'b0);
                check("t4_busy", b4, 1'b0);
            end
        end

        // Test 5: negative bit patterns pass untouched
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            v4 = (c == 0);
            a4 = (c == 0) ? 8'hFF : 8'h00;
            c4 = 1'b0;
            din4 = '0;
            if (c < 4) din4[c] = (c % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            sample();
            if (c == 4) begin
                check("t5_valid", vo4, 1'b1);
                check("t5_data", dout4, {32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
                check("t5_addr", ao4, 8'hFF);
            end
        end

        // Test 6: MATRIX_WIDTH = 14, random rows and random enable
        ecount = 0;
        mcount = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            next_cycle();
            en14 = ($urandom_range(0, 3) != 0);
            if (en14) begin
                oi = ecount % 32;
                rv[oi] = ($urandom_range(0, 4) < 3);
                ra[oi] = 8'($urandom);
                rc[oi] = 1'($urandom);
                for (int j = 0; j < 14; j++) rw[oi][j] = $urandom;
                v14 = rv[oi];
                a14 = ra[oi];
                c14 = rc[oi];
                for (int j = 0; j < 14; j++) begin
                    din14[j] = (ecount >= j) ? rw[(ecount - j) % 32][j] : 32'h0;
                end
            end else begin
                v14 = 1'($urandom);
                a14 = 8'($urandom);
                c14 = 1'($urandom);
                for (int j = 0; j < 14; j++) din14[j] = $urandom;
            end
            sample();
            exp_v = 1'b0;
            oi = 0;
            if (en14 && ecount >= 14) begin
                oi = (ecount - 14) % 32;
                exp_v = rv[oi];
            end
            check("t6_valid", vo14, exp_v);
            check("t6_busy", b14, (mcount != 0));
            if (exp_v) begin
                for (int j = 0; j < 14; j++) exp_row[j] = rw[oi][j];
                check("t6_data", dout14, exp_row);
                check("t6_addr", ao14, ra[oi]);
                check("t6_acc", co14, rc[oi]);
            end
            if (en14) begin
                mcount = mcount + (v14 ? 1 : 0) - (exp_v ? 1 : 0);
                ecount++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
